fpu_add_sub_special_pipe: RTL and testbench

//  Parametrised, pipelined special-case (fast-path) unit for FP add/sub. Classifies both operands

---
 rtl/fpu_add_sub_special_pipe.sv | 161 ++++++++++++++++
 tb/tb_fpu_add_sub_special_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_sub_special_pipe.sv
// Fast-path resolver for FP add/sub special operands (zero/inf/NaN) behind a valid/ready pipeline.
// Optional build macro FPU_FAST_SUBNORM_FTZ_EN: subnormal operands are treated as signed zeros.
module fpu_add_sub_special_pipe #(
    parameter int unsigned EXP_W       = 8,
    parameter int unsigned MAN_W       = 23,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   op_a_i,
    input  logic [EXP_W+MAN_W:0]   op_b_i,
    input  logic                   sub_op_i,
    input  logic [2:0]             rm_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   fast_sel_o,
    output logic [EXP_W+MAN_W:0]   fast_res_o,
    output logic                   nv_o,
    output logic                   fflags_nv_o,
    input  logic                   clr_flags_i
);

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam logic [2:0]  RM_RDN = 3'b010;
    localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } cls_t;

    typedef struct packed {
        logic         sel;
        logic         nv;
        logic [W-1:0] res;
    } stage_t;

    function automatic cls_t classify(input logic [W-1:0] v, input logic flip);
        cls_t             c;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e      = v[W-2:MAN_W];
        m      = v[MAN_W-1:0];
        c.sign = v[W-1] ^ flip;
        c.inf  = (e == '1) && (m == '0);
        c.nan  = (e == '1) && (m != '0);
        c.snan = c.nan && !m[MAN_W-1];
`ifdef FPU_FAST_SUBNORM_FTZ_EN
        c.zero = (e == '0);
`else
        c.zero = (e == '0) && (m == '0);
`endif
        return c;
    endfunction

    cls_t   ca, cb;
    stage_t fast;

    always_comb begin
        ca       = classify(op_a_i, 1'b0);
        cb       = classify(op_b_i, sub_op_i);
        fast.sel = 1'b1;
        fast.nv  = 1'b0;
        fast.res = '0;
        if (ca.nan || cb.nan) begin
            fast.res = QNAN;
            fast.nv  = ca.snan || cb.snan;
        end else if (ca.inf && cb.inf) begin
            if (ca.sign == cb.sign) begin
                fast.res = op_a_i;
            end else begin
                fast.res = QNAN;
                fast.nv  = 1'b1;
            end
        end else if (ca.inf) begin
            fast.res = op_a_i;
        end else if (cb.inf) begin
            fast.res = {cb.sign, op_b_i[W-2:0]};
        end else if (ca.zero && cb.zero) begin
            // exact-zero result: the sign comes from operands, or from rm when they disagree
            fast.res = {((ca.sign == cb.sign) ? ca.sign : (rm_i == RM_RDN)), {(W-1){1'b0}}};
        end else if (ca.zero) begin
            fast.res = {cb.sign, op_b_i[W-2:0]};
        end else if (cb.zero) begin
            fast.res = op_a_i;
        end else begin
            fast.sel = 1'b0;
        end
    end

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] src_vld;
    stage_t                 stg [PIPE_STAGES];
    stage_t                 src [PIPE_STAGES];

    // a stage can load when it or any stage after it holds a bubble, or the consumer drains
    always_comb begin
        for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            load[k] = out_ready_i;
            for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
                if (j >= k && !vld[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        src_vld[0] = in_valid_i;
        src[0]     = in_valid_i ? fast : '0;
        for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
            src_vld[k] = vld[k-1];
            src[k]     = stg[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vld <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                stg[k] <= '0;
            end
        end else if (flush_i) begin
            vld <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                stg[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= src_vld[k];
                    stg[k] <= src[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fflags_nv_o <= 1'b0;
        end else if (out_valid_o && out_ready_i && nv_o) begin
            fflags_nv_o <= 1'b1;
        end else if (clr_flags_i) begin
            fflags_nv_o <= 1'b0;
        end
    end

    assign in_ready_o  = load[0];
    assign out_valid_o = vld[PIPE_STAGES-1];
    assign fast_sel_o  = stg[PIPE_STAGES-1].sel;
    assign nv_o        = stg[PIPE_STAGES-1].nv;
    assign fast_res_o  = stg[PIPE_STAGES-1].res;

endmodule

// File: tb/tb_fpu_add_sub_special_pipe.sv
// Self-checking bench for fpu_add_sub_special_pipe (PIPE_STAGES=2, binary32 format).
module tb_fpu_add_sub_special_pipe;

    localparam int PS = 2;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, in_valid_i, in_ready_o;
    logic [31:0] op_a_i, op_b_i;
    logic        sub_op_i;
    logic [2:0]  rm_i;
    logic        out_valid_o, out_ready_i, fast_sel_o, nv_o, fflags_nv_o, clr_flags_i;
    logic [31:0] fast_res_o;

    int   total = 0;
    int   bad   = 0;
    logic exp_sticky = 1'b0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        sel;
        logic        nv;
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] exp_q[$];

    fpu_add_sub_special_pipe #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(PS)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .sub_op_i(sub_op_i), .rm_i(rm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .fast_sel_o(fast_sel_o), .fast_res_o(fast_res_o), .nv_o(nv_o),
        .fflags_nv_o(fflags_nv_o), .clr_flags_i(clr_flags_i)
    );

    always #5 clk = ~clk;

    // reference: {sel, nv, res} from operand classes in binary32
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [2:0] rm);
        logic sa, sb, na, nb, sna, snb, ia, ib, za, zb;
        logic [31:0] qnan, beff;
        qnan = 32'h7FC00000;
        sa   = a[31];
        sb   = b[31] ^ sub;
        beff = {sb, b[30:0]};
        na   = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb   = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sna  = na && (a[22] == 1'b0);
        snb  = nb && (b[22] == 1'b0);
        ia   = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib   = (b[30:23] == 8'hFF) && (b[22:0] == 0);
`ifdef FPU_FAST_SUBNORM_FTZ_EN
        za   = (a[30:23] == 8'h00);
        zb   = (b[30:23] == 8'h00);
`else
        za   = (a[30:0] == 31'h0);
        zb   = (b[30:0] == 31'h0);
`endif
        if (na || nb)        return {1'b1, (sna || snb), qnan};
        if (ia && ib)        return (sa == sb) ? {2'b10, sa, 8'hFF, 23'h0} : {2'b11, qnan};
        if (ia)              return {2'b10, a};
        if (ib)              return {2'b10, beff};
        if (za && zb) begin
            if (sa == sb)    return {2'b10, sa, 31'h0};
            return {2'b10, (rm == 3'b010), 31'h0};
        end
        if (za)              return {2'b10, beff};
        if (zb)              return {2'b10, a};
        return 34'h0;
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned k;
        logic [31:0] r;
        logic [7:0]  e;
        k = $urandom_range(0, 7);
        r = $urandom;
        e = 8'($urandom_range(1, 254));
        case (k)
            0: return {r[31], 31'h0};
            1: return {r[31], 8'hFF, 23'h0};
            2: return {r[31], 8'hFF, 1'b1, r[21:0]};
            3: return {r[31], 8'hFF, 1'b0, r[21:0] | 22'h1};
            4: return {r[31], 8'h00, r[22:0] | 23'h1};
            default: return {r[31], e, r[22:0]};
        endcase
    endfunction

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [2:0] rm, input logic [31:0] res, input logic sel,
                           input logic nv);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.rm = rm; v.res = res; v.sel = sel; v.nv = nv;
        vecs.push_back(v);
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid_o); end
        total++; if (fast_sel_o !== 1'b0) begin bad++; $display("FAIL reset_fast_sel: got %b exp 0", fast_sel_o); end
        total++; if (fast_res_o !== 32'h0) begin bad++; $display("FAIL reset_fast_res: got %h exp 0", fast_res_o); end
        total++; if (nv_o !== 1'b0) begin bad++; $display("FAIL reset_nv: got %b exp 0", nv_o); end
        total++; if (fflags_nv_o !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b exp 0", fflags_nv_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready_o); end
    endtask

    task automatic test_directed();
        int lat;
        add_vec(32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 1'b1, 1'b1);
        add_vec(32'h00000000, 32'h00000000, 1'b1, 3'd0, 32'h00000000, 1'b1, 1'b0);
        add_vec(32'h00000000, 32'h00000000, 1'b1, 3'd2, 32'h80000000, 1'b1, 1'b0);
        add_vec(32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 1'b1, 1'b1);
        add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 1'b1, 1'b0);
        add_vec(32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFF800000, 1'b1, 1'b0);
        add_vec(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0);
`ifdef FPU_FAST_SUBNORM_FTZ_EN
        add_vec(32'h00000001, 32'h3F800000, 1'b0, 3'd0, 32'h3F800000, 1'b1, 1'b0);
`else
        add_vec(32'h00000001, 32'h3F800000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0);
`endif
        add_vec(32'h7F800001, 32'h7FC00000, 1'b0, 3'd0, 32'h7FC00000, 1'b1, 1'b1);
        add_vec(32'hFF800000, 32'h7F800000, 1'b1, 3'd1, 32'hFF800000, 1'b1, 1'b0);
        add_vec(32'h80000000, 32'h00000000, 1'b0, 3'd2, 32'h80000000, 1'b1, 1'b0);
        add_vec(32'h80000000, 32'h00000000, 1'b0, 3'd3, 32'h00000000, 1'b1, 1'b0);
        add_vec(32'h80000000, 32'h00000000, 1'b0, 3'd6, 32'h00000000, 1'b1, 1'b0);
        add_vec(32'h3F800000, 32'h80000000, 1'b0, 3'd0, 32'h3F800000, 1'b1, 1'b0);
        add_vec(32'h00000000, 32'hC0000000, 1'b1, 3'd0, 32'h40000000, 1'b1, 1'b0);
        foreach (vecs[i]) begin
            @(negedge clk);
            op_a_i = vecs[i].a; op_b_i = vecs[i].b; sub_op_i = vecs[i].sub; rm_i = vecs[i].rm;
            in_valid_i = 1'b1; out_ready_i = 1'b1;
            @(negedge clk);
            in_valid_i = 1'b0;
            lat = 1;
            while (!out_valid_o && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            total++; if (lat !== PS) begin bad++; $display("FAIL dir%0d_latency: got %0d exp %0d", i, lat, PS); end
            total++; if (fast_res_o !== vecs[i].res) begin bad++; $display("FAIL dir%0d_res: got %h exp %h", i, fast_res_o, vecs[i].res); end
            total++; if (fast_sel_o !== vecs[i].sel) begin bad++; $display("FAIL dir%0d_sel: got %b exp %b", i, fast_sel_o, vecs[i].sel); end
            total++; if (nv_o !== vecs[i].nv) begin bad++; $display("FAIL dir%0d_nv: got %b exp %b", i, nv_o, vecs[i].nv); end
            exp_sticky = exp_sticky | vecs[i].nv;
            @(negedge clk);
            total++; if (fflags_nv_o !== exp_sticky) begin bad++; $display("FAIL dir%0d_sticky: got %b exp %b", i, fflags_nv_o, exp_sticky); end
            total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL dir%0d_drained: got %b exp 0", i, out_valid_o); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa[3];
        logic [31:0] ob[3];
        logic        os[3];
        int          acc;
        oa[0] = 32'h7F800000; ob[0] = 32'hFF800000; os[0] = 1'b0;
        oa[1] = 32'h3F800000; ob[1] = 32'h7F800000; os[1] = 1'b1;
        oa[2] = 32'h3F800000; ob[2] = 32'h40000000; os[2] = 1'b0;
        @(negedge clk);
        in_valid_i = 1'b0; out_ready_i = 1'b0; clr_flags_i = 1'b1; rm_i = 3'd0;
        @(negedge clk);
        clr_flags_i = 1'b0;
        exp_sticky = 1'b0;
        total++; if (fflags_nv_o !== 1'b0) begin bad++; $display("FAIL bb_clear: got %b exp 0", fflags_nv_o); end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            op_a_i = oa[i]; op_b_i = ob[i]; sub_op_i = os[i]; in_valid_i = 1'b1;
            #1;
            if (in_ready_o) acc++;
            @(negedge clk);
        end
        #1;
        total++; if (acc !== PS) begin bad++; $display("FAIL bb_accepted: got %0d exp %0d", acc, PS); end
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bb_in_ready_full: got %b exp 0", in_ready_o); end
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({out_valid_o, nv_o, fast_res_o} !== {2'b11, 32'h7FC00000}) begin
                bad++; $display("FAIL bb_stall%0d: got v=%b nv=%b res=%h exp v=1 nv=1 res=7fc00000", i, out_valid_o, nv_o, fast_res_o);
            end
        end
        out_ready_i = 1'b1; clr_flags_i = 1'b1;
        #1;
        total++; if (fast_res_o !== 32'h7FC00000) begin bad++; $display("FAIL bb_first: got %h exp 7fc00000", fast_res_o); end
        @(negedge clk);
        clr_flags_i = 1'b0;
        exp_sticky = 1'b1;
        total++; if ({out_valid_o, nv_o, fast_res_o} !== {2'b10, 32'hFF800000}) begin
            bad++; $display("FAIL bb_second: got v=%b nv=%b res=%h exp v=1 nv=0 res=ff800000", out_valid_o, nv_o, fast_res_o);
        end
        total++; if (fflags_nv_o !== 1'b1) begin bad++; $display("FAIL bb_set_wins: got %b exp 1", fflags_nv_o); end
        @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bb_empty: got %b exp 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        op_a_i = 32'h7F800001; op_b_i = 32'h3F800000; sub_op_i = 1'b0; in_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL fl_prefill: got %b exp 1", out_valid_o); end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; in_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL fl_cleared: got %b exp 0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL fl_in_ready: got %b exp 1", in_ready_o); end
        total++; if (fflags_nv_o !== exp_sticky) begin bad++; $display("FAIL fl_sticky: got %b exp %b", fflags_nv_o, exp_sticky); end
        @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL fl_no_accept: got %b exp 0", out_valid_o); end
    endtask

    task automatic test_reset_midop();
        out_ready_i = 1'b0;
        op_a_i = 32'h7F800000; op_b_i = 32'hFF800000; sub_op_i = 1'b0; in_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        reset_i = 1'b0;
        exp_sticky = 1'b0;
        #1;
        total++; if ({out_valid_o, fast_sel_o, nv_o, fflags_nv_o, fast_res_o} !== 36'h0) begin
            bad++; $display("FAIL rst_mid: got v=%b sel=%b nv=%b st=%b res=%h exp all 0", out_valid_o, fast_sel_o, nv_o, fflags_nv_o, fast_res_o);
        end
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({out_valid_o, in_ready_o} !== 2'b01) begin
                bad++; $display("FAIL rst_stale%0d: got v=%b rdy=%b exp v=0 rdy=1", i, out_valid_o, in_ready_o);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] front;
        logic        drain;
        for (int cyc = 0; cyc < 2040; cyc++) begin
            drain = (cyc >= 2000);
            @(negedge clk);
            in_valid_i  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
            op_a_i      = rand_op();
            op_b_i      = rand_op();
            sub_op_i    = 1'($urandom_range(0, 1));
            rm_i        = 3'($urandom_range(0, 7));
            out_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            clr_flags_i = ($urandom_range(0, 15) == 0);
            #1;
            total++; if (fflags_nv_o !== exp_sticky) begin bad++; $display("FAIL rnd_sticky@%0d: got %b exp %b", cyc, fflags_nv_o, exp_sticky); end
            front = 34'h0;
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_spurious@%0d: got out_valid=1 exp 0", cyc);
                end else begin
                    front = exp_q[0];
                    total++; if ({fast_sel_o, nv_o, fast_res_o} !== front) begin
                        bad++; $display("FAIL rnd_result@%0d: got %h exp %h", cyc, {fast_sel_o, nv_o, fast_res_o}, front);
                    end
                    if (out_ready_i) void'(exp_q.pop_front());
                end
            end
            if (out_valid_o && out_ready_i && front[32]) exp_sticky = 1'b1;
            else if (clr_flags_i) exp_sticky = 1'b0;
            if (in_valid_i && in_ready_o) exp_q.push_back(model(op_a_i, op_b_i, sub_op_i, rm_i));
        end
        clr_flags_i = 1'b0;
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rnd_drain: got %0d pending exp 0", exp_q.size()); end
    endtask

    initial begin
        reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; op_a_i = '0; op_b_i = '0;
        sub_op_i = 1'b0; rm_i = '0; out_ready_i = 1'b0; clr_flags_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
